if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage: PC register, instruction-memory request handshake and the IF/ID pipeline register.
//  Produces pc_plus4_ID / inst_ID for decode and branch resolution.
//  Consumes the branch unit's is_branch / branch_address / is_rst_IF_ID.
//  Tolerates variable-latency imem and ID-stage stalls without losing or duplicating instructions.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   reset, synchronous, active-high (`RstEnable)
//  stall_IF        in   1   hazard unit: hold PC and IF/ID this cycle
//  is_branch       in   1   redirect request from branch resolution in ID
//  branch_address  in   32  redirect target; bits [1:0] forced to 00
//  is_rst_IF_ID    in   1   flush IF/ID (insert bubble)
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch address, registered
//  imem_rdata      in   32  instruction word, valid when imem_ready
//  imem_ready      in   1   imem completes the outstanding request this cycle
//  pc_plus4_ID     out  32  IF/ID: fetch address + 4
//  inst_ID         out  32  IF/ID: instruction (`ZeroWord = nop when bubble)
//  valid_ID        out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - pc=RESET_PC, imem_req=0, imem_addr=0, inst_ID=0, pc_plus4_ID=0, valid_ID=0, buf cleared, state=IDLE.
//   - Reset overrides every other input, including mid-request; a late imem_ready is ignored.
//  Handshake: once imem_req=1, imem_addr is stable until the cycle imem_ready=1.
//   - imem_ready is sampled only while imem_req=1.
//  FSM:
//   - IDLE: imem_req=0; next cycle -> REQ, imem_addr<=pc.
//   - REQ: imem_req=1.
//     - On ready with no redirect and no stall: IF/ID<={imem_rdata, imem_addr+4, valid=1}; pc, imem_addr <= imem_addr+4; stay REQ.
//       This gives back-to-back fetch, 1 instr/cycle when ready is held high.
//     - On ready with stall_IF: capture word and addr into buf; -> HOLD; IF/ID unchanged.
//   - HOLD: imem_req=0. When stall_IF=0: IF/ID<=buf, valid=1; imem_addr<=buf_addr+4; -> REQ.
//   - DROP: imem_req=1 at the stale address. On ready the data is discarded; imem_addr<=pc (the target); -> REQ.
//  Redirect (is_branch=1), priority over stall_IF for the PC path:
//   - pc<=branch_address.
//   - REQ with ready: data discarded; imem_addr<=target; stay REQ.
//   - REQ without ready: -> DROP.
//   - HOLD: buf discarded; imem_addr<=target; -> REQ.
//   - IDLE: target becomes the first fetch.
//  IF/ID register, priority order:
//   1. is_rst_IF_ID: inst_ID=0, valid_ID=0, pc_plus4_ID=0.
//   2. stall_IF: hold.
//   3. load as above.
//   4. Otherwise, when no instruction is delivered: bubble (inst_ID=0, valid_ID=0).
//  No branch delay slot: the instruction in IF at redirect time is never delivered.
//  Arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
// TESTING
//  - Reset: rst=1 two cycles, then 0 -> imem_req rises on the 2nd cycle after release with imem_addr=RESET_PC; all IF/ID outputs 0.
//  - Straight line, ready=1 every cycle -> inst_ID takes rdata of addrs 0,4,8 on consecutive cycles; pc_plus4_ID=4,8,12; valid_ID=1.
//  - Stall capture: stall_IF=1 on the cycle ready returns the instr at 0x10 -> HOLD, imem_req=0.
//    After stall drops: inst_ID=that word, pc_plus4_ID=0x14, next fetch 0x14.
//  - Redirect while waiting: is_branch+is_rst_IF_ID, target 0x40, with no ready -> DROP, imem_addr held.
//    Ready 3 cycles later -> data discarded; next imem_addr=0x40; valid_ID=0 until 0x40 returns.
//  - Redirect with simultaneous ready and stall_IF=1 -> the returned word is never delivered; imem_addr=target next cycle; IF/ID flushed.
//  - Reset mid-DROP, then imem_ready pulse -> ignored; fetch restarts at RESET_PC; wrap check: pc 32'hFFFF_FFFC fetch gives pc_plus4_ID=0.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and imem (slave).
// The address is held stable from the cycle imem_req rises until imem_ready completes it.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem request FSM with a one-entry stall buffer, and IF/ID register.
// Redirects discard any in-flight or buffered word, so nothing behind a branch is ever delivered.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_IF,
  input  logic                     is_branch,
  input  logic [31:0]              branch_address,
  input  logic                     is_rst_IF_ID,
  if_fetch_stage_if.master         imem,
  output logic [31:0]              pc_plus4_ID,
  output logic [31:0]              inst_ID,
  output logic                     valid_ID
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] addr_q;
  logic [31:0] addr_next;
  logic [31:0] buf_inst;
  logic [31:0] buf_inst_next;
  logic [31:0] buf_addr;
  logic [31:0] buf_addr_next;

  logic        deliver;
  logic [31:0] deliver_inst;
  logic [31:0] deliver_pc4;

  logic [31:0] target;
  logic [31:0] addr_plus4;
  logic [31:0] buf_plus4;

  assign target     = branch_address & 32'hFFFF_FFFC;
  assign addr_plus4 = addr_q + 32'd4;
  assign buf_plus4  = buf_addr + 32'd4;

  assign imem.imem_req  = (state == REQ) || (state == DROP);
  assign imem.imem_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      addr_q   <= 32'h0000_0000;
      buf_inst <= 32'h0000_0000;
      buf_addr <= 32'h0000_0000;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      addr_q   <= addr_next;
      buf_inst <= buf_inst_next;
      buf_addr <= buf_addr_next;
    end
  end

  // Redirect always wins the PC path; a stalled return parks in buf instead of being refetched.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    addr_next     = addr_q;
    buf_inst_next = buf_inst;
    buf_addr_next = buf_addr;
    deliver       = 1'b0;
    deliver_inst  = 32'h0000_0000;
    deliver_pc4   = 32'h0000_0000;

    case (state)
      IDLE: begin
        state_next = REQ;
        if (is_branch) begin
          pc_next   = target;
          addr_next = target;
        end else begin
          addr_next = pc;
        end
      end

      REQ: begin
        if (is_branch) begin
          pc_next = target;
          if (imem.imem_ready) begin
            addr_next = target;
          end else begin
            state_next = DROP;
          end
        end else if (imem.imem_ready) begin
          if (stall_IF) begin
            buf_inst_next = imem.imem_rdata;
            buf_addr_next = addr_q;
            state_next    = HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_inst = imem.imem_rdata;
            deliver_pc4  = addr_plus4;
            pc_next      = addr_plus4;
            addr_next    = addr_plus4;
          end
        end
      end

      HOLD: begin
        if (is_branch) begin
          pc_next    = target;
          addr_next  = target;
          state_next = REQ;
        end else if (!stall_IF) begin
          deliver      = 1'b1;
          deliver_inst = buf_inst;
          deliver_pc4  = buf_plus4;
          pc_next      = buf_plus4;
          addr_next    = buf_plus4;
          state_next   = REQ;
        end
      end

      DROP: begin
        // The stale request must still complete before the target can be issued.
        if (is_branch) begin
          pc_next = target;
        end
        if (imem.imem_ready) begin
          addr_next  = is_branch ? target : pc;
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Flush beats stall beats load; with nothing delivered the slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_ID     <= 32'h0000_0000;
      pc_plus4_ID <= 32'h0000_0000;
      valid_ID    <= 1'b0;
    end else if (is_rst_IF_ID) begin
      inst_ID     <= 32'h0000_0000;
      pc_plus4_ID <= 32'h0000_0000;
      valid_ID    <= 1'b0;
    end else if (stall_IF) begin
      inst_ID     <= inst_ID;
      pc_plus4_ID <= pc_plus4_ID;
      valid_ID    <= valid_ID;
    end else if (deliver) begin
      inst_ID     <= deliver_inst;
      pc_plus4_ID <= deliver_pc4;
      valid_ID    <= 1'b1;
    end else begin
      inst_ID     <= 32'h0000_0000;
      valid_ID    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a scoreboard holds expected deliveries, and a monitor
// pops one entry each time decode accepts a valid IF/ID word (valid_ID with no stall).
module tb_if_fetch_stage;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall_IF;
  logic        is_branch;
  logic [31:0] branch_address;
  logic        is_rst_IF_ID;
  logic        ready_drv;
  logic [31:0] pc_plus4_ID;
  logic [31:0] inst_ID;
  logic        valid_ID;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  if_fetch_stage_if imem_bus();

  // Each imem word is its address xored with a tag, so a wrong address shows up in the data.
  assign imem_bus.imem_rdata = 32'hC0DE_0000 ^ imem_bus.imem_addr;
  assign imem_bus.imem_ready = ready_drv;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_IF       (stall_IF),
    .is_branch      (is_branch),
    .branch_address (branch_address),
    .is_rst_IF_ID   (is_rst_IF_ID),
    .imem           (imem_bus),
    .pc_plus4_ID    (pc_plus4_ID),
    .inst_ID        (inst_ID),
    .valid_ID       (valid_ID)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic r, input logic s, input logic b,
                                input logic [31:0] t, input logic f, input logic rd);
    rst            = r;
    stall_IF       = s;
    is_branch      = b;
    branch_address = t;
    is_rst_IF_ID   = f;
    ready_drv      = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] inst, input logic [31:0] pc4);
    exp_t e;
    e.inst = inst;
    e.pc4  = pc4;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && valid_ID && !stall_IF) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_delivery: got inst %h pc4 %h expected none", inst_ID, pc_plus4_ID);
      end else begin
        e = sb.pop_front();
        if (inst_ID !== e.inst || pc_plus4_ID !== e.pc4) begin
          errors++;
          $display("[TB] FAIL delivery: got inst %h pc4 %h expected inst %h pc4 %h",
                   inst_ID, pc_plus4_ID, e.inst, e.pc4);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall_IF = 1'b0; is_branch = 1'b0; branch_address = '0;
    is_rst_IF_ID = 1'b0; ready_drv = 1'b0;

    // Reset held two cycles
    apply_stimulus(1, 0, 0, 32'h0, 0, 0);
    apply_stimulus(1, 0, 0, 32'h0, 0, 1);
    check_output("reset_req",   {31'b0, imem_bus.imem_req}, 32'h0);
    check_output("reset_addr",  imem_bus.imem_addr, 32'h0);
    check_output("reset_inst",  inst_ID, 32'h0);
    check_output("reset_pc4",   pc_plus4_ID, 32'h0);
    check_output("reset_valid", {31'b0, valid_ID}, 32'h0);

    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("first_req",  {31'b0, imem_bus.imem_req}, 32'h1);
    check_output("first_addr", imem_bus.imem_addr, 32'h0);

    // Straight-line fetch, ready every cycle
    expect_word(32'hC0DE_0000, 32'h4);
    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("line_inst0", inst_ID, 32'hC0DE_0000);
    check_output("line_pc4_0", pc_plus4_ID, 32'h4);
    expect_word(32'hC0DE_0004, 32'h8);
    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("line_pc4_1", pc_plus4_ID, 32'h8);
    expect_word(32'hC0DE_0008, 32'hC);
    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("line_pc4_2", pc_plus4_ID, 32'hC);
    expect_word(32'hC0DE_000C, 32'h10);
    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("line_addr", imem_bus.imem_addr, 32'h10);

    // Stall on the cycle 0x10 returns: word parks in the buffer
    apply_stimulus(0, 1, 0, 32'h0, 0, 1);
    check_output("hold_req",  {31'b0, imem_bus.imem_req}, 32'h0);
    check_output("hold_inst", inst_ID, 32'hC0DE_000C);
    apply_stimulus(0, 1, 0, 32'h0, 0, 0);
    check_output("hold_req2", {31'b0, imem_bus.imem_req}, 32'h0);
    expect_word(32'hC0DE_0010, 32'h14);
    apply_stimulus(0, 0, 0, 32'h0, 0, 0);
    check_output("release_inst", inst_ID, 32'hC0DE_0010);
    check_output("release_pc4",  pc_plus4_ID, 32'h14);
    check_output("release_addr", imem_bus.imem_addr, 32'h14);
    check_output("release_req",  {31'b0, imem_bus.imem_req}, 32'h1);

    // Redirect to 0x40 while 0x14 is outstanding
    apply_stimulus(0, 0, 1, 32'h40, 1, 0);
    check_output("drop_addr",  imem_bus.imem_addr, 32'h14);
    check_output("drop_req",   {31'b0, imem_bus.imem_req}, 32'h1);
    check_output("drop_valid", {31'b0, valid_ID}, 32'h0);
    apply_stimulus(0, 0, 0, 32'h0, 0, 0);
    apply_stimulus(0, 0, 0, 32'h0, 0, 0);
    check_output("drop_addr_held", imem_bus.imem_addr, 32'h14);
    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("drop_done_addr",  imem_bus.imem_addr, 32'h40);
    check_output("drop_done_valid", {31'b0, valid_ID}, 32'h0);
    apply_stimulus(0, 0, 0, 32'h0, 0, 0);
    check_output("drop_wait_valid", {31'b0, valid_ID}, 32'h0);
    expect_word(32'hC0DE_0040, 32'h44);
    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("target_inst", inst_ID, 32'hC0DE_0040);

    // Redirect with ready and stall together: the 0x44 word must vanish
    apply_stimulus(0, 0, 0, 32'h0, 0, 0);
    apply_stimulus(0, 1, 1, 32'h80, 1, 1);
    check_output("brstall_addr",  imem_bus.imem_addr, 32'h80);
    check_output("brstall_valid", {31'b0, valid_ID}, 32'h0);
    check_output("brstall_inst",  inst_ID, 32'h0);
    expect_word(32'hC0DE_0080, 32'h84);
    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("brstall_next", inst_ID, 32'hC0DE_0080);

    // Reset in the middle of a DROP, then a stray ready pulse
    apply_stimulus(0, 0, 1, 32'h100, 1, 0);
    apply_stimulus(1, 0, 0, 32'h0, 0, 1);
    check_output("midrst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
    check_output("midrst_addr",  imem_bus.imem_addr, 32'h0);
    check_output("midrst_valid", {31'b0, valid_ID}, 32'h0);
    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("restart_addr",  imem_bus.imem_addr, 32'h0);
    check_output("restart_req",   {31'b0, imem_bus.imem_req}, 32'h1);
    check_output("restart_valid", {31'b0, valid_ID}, 32'h0);
    apply_stimulus(0, 0, 0, 32'h0, 0, 0);
    check_output("restart_hold", imem_bus.imem_addr, 32'h0);

    // Misaligned target is forced to 0xFFFF_FFFC, and +4 wraps to zero
    apply_stimulus(0, 0, 1, 32'hFFFF_FFFF, 1, 1);
    check_output("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    expect_word(32'h3F21_FFFC, 32'h0);
    apply_stimulus(0, 0, 0, 32'h0, 0, 1);
    check_output("wrap_pc4",   pc_plus4_ID, 32'h0);
    check_output("wrap_inst",  inst_ID, 32'h3F21_FFFC);
    check_output("wrap_next",  imem_bus.imem_addr, 32'h0);
    apply_stimulus(0, 0, 0, 32'h0, 0, 0);
    apply_stimulus(0, 0, 0, 32'h0, 0, 0);
    apply_stimulus(0, 0, 0, 32'h0, 0, 0);

    check_output("scoreboard_left", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
